seg_scan_display: RTL
=====================

// Module: seg_scan_display
// PURPOSE
//  Downstream display stage for the card-game core. Consumes the 4-digit BCD result
//  word (bcdResults16) and the two player finish flags, then drives a 4-digit,
//  time-multiplexed, common-anode 7-segment display.
//  Provides digit scanning, tear-free frame latching, leading-zero blanking, a
//  "----" idle pattern and a game-over indication.
// PARAMETERS
//  SCAN_DIV   50000  clock cycles each digit stays lit (>=2)
//  BLINK_DIV  16     full scan frames per blink half-period (>=1; used only with SEG_BLINK_EN)
// PORTS
//  clock         in   1   system clock, all logic on rising edge
//  new_Game      in   1   synchronous active-high reset
//  bcdResults16  in   16  BCD digits {d3,d2,d1,d0}; d0 = units
//  finishMaster  in   1   master player finished
//  finishSlave   in   1   slave player finished
//  seg_an        out  4   digit enables, active-low; seg_an[i] = digit i, digit 0 rightmost
//  seg_cat       out  8   segments, active-low: [6:0] = g..a, [7] = dp (dp always off)
//  digit_sel     out  2   index of the digit currently driven
// BEHAVIOUR
//  Reset (new_Game=1 at an edge), effective next cycle:
//   - prescaler=0, digit_sel=0, bcd_q=0, state=IDLE, blink phase=0
//   - seg_an=4'hF, seg_cat=8'hFF
//   - new_Game mid-scan aborts the scan with no partial frame.
//  Prescaler: counts 0..SCAN_DIV-1 and wraps; tick asserts when count==SCAN_DIV-1.
//  digit_sel: increments on tick, wrapping 3->0. Wrap 3->0 is the frame boundary.
//  Snapshot: bcd_q<=bcdResults16 only at the frame boundary (and 0 on reset).
//   - An input change mid-frame is shown from the next frame; no tearing.
//  Outputs are registered from digit_sel and bcd_q: 1-cycle latency after digit_sel changes.
//  FSM on {finishMaster, finishSlave}, evaluated every cycle:
//   IDLE    neither finished: every digit shows dash (seg_cat=8'hBF)
//   PARTIAL exactly one finished: show bcd_q
//   DONE    both finished: show bcd_q (blinks if SEG_BLINK_EN)
//   - Transitions follow the flags directly; any state goes to IDLE when both flags are low.
//   - Both flags rising in the same cycle go IDLE->DONE directly.
//  Decode (active-low):
//   0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90
//   nibble 10..15 -> BF (dash)
//  Leading-zero blanking (PARTIAL/DONE only), blank means seg_cat=FF with seg_an still scanning:
//   - d3 blank if d3==0
//   - d2 blank if d3==d2==0
//   - d1 blank if d3..d1==0
//   - d0 never blanked
//   - a dash nibble counts as non-zero
//  seg_an = ~(4'b0001<<digit_sel), except during blink-off.
// CONFIGURATION
//  SEG_BLINK_EN defined:
//   - Frame counter counts BLINK_DIV frames, then toggles the blink phase.
//   - In DONE with phase=1: seg_an=4'hF. Phase is cleared on entry to DONE.
//  SEG_BLINK_EN undefined:
//   - No frame counter or phase register.
//   - DONE is displayed identically to PARTIAL.
// TESTING (SCAN_DIV=4, BLINK_DIV=2)
//  1 Reset: hold new_Game 3 cycles -> seg_an=F, seg_cat=FF, digit_sel=0.
//  2 Idle: flags 0, run 1 frame -> seg_an steps E,D,B,7 every 4 cycles; seg_cat=BF throughout.
//  3 Blanking: bcd=0x0021, finishMaster=1, wait 1 boundary
//     -> d0=F9, d1=A4, d2/d3 seg_cat=FF; bcd=0x1005 -> d3..d0 = F9,C0,C0,92.
//  4 Tearing: change bcd 0x0021->0x0099 while digit_sel=1
//     -> rest of frame shows 0x0021; next frame shows 90,90.
//  5 Blink (SEG_BLINK_EN): both flags=1 -> 2 frames scanning, 2 frames seg_an=F, repeating;
//     without the macro -> continuous scan.
//  6 Mid-scan reset: pulse new_Game at digit_sel=2
//     -> next cycle reset values; scan restarts at digit 0 after SCAN_DIV cycles.

Source files
------------

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//
// Display stage for the card-game core. Latches the 4-digit BCD result once per
// scan frame and drives a time-multiplexed, common-anode 4-digit 7-segment
// display. It does leading-zero blanking, shows a "----" idle pattern while no
// player has finished, and can blink the display once both players are done.
//
// Configuration macro:
//   SEG_BLINK_EN  defined   -> the display blinks in the game-over state
//                             (BLINK_DIV frames on, BLINK_DIV frames off)
//                 undefined -> the game-over state looks the same as the
//                             one-player-finished state
//
// Parameters:
//   SCAN_DIV      clock cycles each digit stays lit (>= 2)
//   BLINK_DIV     scan frames per blink half-period (>= 1)
//
// Ports:
//   clock         in   system clock, rising edge
//   new_Game      in   synchronous active-high reset
//   bcdResults16  in   BCD digits {d3,d2,d1,d0}, d0 = units
//   finishMaster  in   master player finished
//   finishSlave   in   slave player finished
//   seg_an        out  digit enables, active-low, bit i = digit i (0 rightmost)
//   seg_cat       out  segments, active-low, [6:0] = g..a, [7] = dp (always off)
//   digit_sel     out  index of the digit currently driven
// -----------------------------------------------------------------------------
module seg_scan_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 16
) (
    input  logic        clock,
    input  logic        new_Game,
    input  logic [15:0] bcdResults16,
    input  logic        finishMaster,
    input  logic        finishSlave,
    output logic [3:0]  seg_an,
    output logic [7:0]  seg_cat,
    output logic [1:0]  digit_sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Out-of-range parameters would silently break the scan timing.
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg_scan_display: SCAN_DIV must be >= 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("seg_scan_display: BLINK_DIV must be >= 1");
    end

    // Active-low segment pattern for one nibble; 10..15 render as a dash.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = 8'hBF;
        endcase
        return pat;
    endfunction

    logic [PW-1:0] prescaler_r;
    logic [1:0]    digit_sel_r;
    logic [15:0]   bcd_q_r;
    state_t        state_r;
    state_t        state_next_s;
    logic          tick_s;
    logic          frame_end_s;
    logic          blink_off_s;
    logic [3:0]    nibble_s;
    logic          blank_s;
    logic [3:0]    an_next_s;
    logic [7:0]    cat_next_s;

    assign tick_s      = (prescaler_r == PW'(SCAN_DIV - 1));
    // The 3->0 wrap of the digit index is the only point where a new frame starts.
    assign frame_end_s = tick_s && (digit_sel_r == 2'd3);
    assign digit_sel   = digit_sel_r;

    // Prescaler: one tick every SCAN_DIV cycles.
    always_ff @(posedge clock) begin
        if (new_Game) begin
            prescaler_r <= {PW{1'b0}};
        end else if (tick_s) begin
            prescaler_r <= {PW{1'b0}};
        end else begin
            prescaler_r <= prescaler_r + PW'(1);
        end
    end

    // Digit index advances on each tick and wraps naturally from 3 to 0.
    always_ff @(posedge clock) begin
        if (new_Game) begin
            digit_sel_r <= 2'd0;
        end else if (tick_s) begin
            digit_sel_r <= digit_sel_r + 2'd1;
        end
    end

    // Result snapshot only at the frame boundary so a frame never mixes two words.
    always_ff @(posedge clock) begin
        if (new_Game) begin
            bcd_q_r <= 16'h0000;
        end else if (frame_end_s) begin
            bcd_q_r <= bcdResults16;
        end
    end

    // Display mode follows the finish flags directly.
    always_comb begin
        state_next_s = ST_IDLE;
        case ({finishMaster, finishSlave})
            2'b00:   state_next_s = ST_IDLE;
            2'b01:   state_next_s = ST_PARTIAL;
            2'b10:   state_next_s = ST_PARTIAL;
            2'b11:   state_next_s = ST_DONE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (new_Game) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [FW-1:0] frame_cnt_r;
    logic          phase_r;
    logic          done_entry_s;

    // Entering DONE restarts the blink so the display always starts in the lit phase.
    assign done_entry_s = (state_next_s == ST_DONE) && (state_r != ST_DONE);
    assign blink_off_s  = (state_r == ST_DONE) && phase_r;

    // Frame counter and blink phase.
    always_ff @(posedge clock) begin
        if (new_Game) begin
            frame_cnt_r <= {FW{1'b0}};
            phase_r     <= 1'b0;
        end else if (done_entry_s) begin
            frame_cnt_r <= {FW{1'b0}};
            phase_r     <= 1'b0;
        end else if (frame_end_s) begin
            if (frame_cnt_r == FW'(BLINK_DIV - 1)) begin
                frame_cnt_r <= {FW{1'b0}};
                phase_r     <= ~phase_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + FW'(1);
            end
        end
    end
`else
    assign blink_off_s = 1'b0;
`endif

    // Select the nibble for the current digit and decide leading-zero blanking:
    // a digit is blank when it and every more significant digit are zero.
    always_comb begin
        nibble_s = 4'h0;
        blank_s  = 1'b0;
        case (digit_sel_r)
            2'd0: begin
                nibble_s = bcd_q_r[3:0];
                blank_s  = 1'b0;
            end
            2'd1: begin
                nibble_s = bcd_q_r[7:4];
                blank_s  = (bcd_q_r[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_s = bcd_q_r[11:8];
                blank_s  = (bcd_q_r[15:8] == 8'h00);
            end
            2'd3: begin
                nibble_s = bcd_q_r[15:12];
                blank_s  = (bcd_q_r[15:12] == 4'h0);
            end
            default: begin
                nibble_s = 4'h0;
                blank_s  = 1'b0;
            end
        endcase
    end

    // Next anode/cathode values; idle shows a dash on every digit.
    always_comb begin
        an_next_s  = 4'hF;
        cat_next_s = 8'hFF;
        if (blink_off_s) begin
            an_next_s = 4'hF;
        end else begin
            an_next_s = ~(4'b0001 << digit_sel_r);
        end
        if (state_r == ST_IDLE) begin
            cat_next_s = 8'hBF;
        end else if (blank_s) begin
            cat_next_s = 8'hFF;
        end else begin
            cat_next_s = seg_decode(nibble_s);
        end
    end

    // Registered display outputs, one cycle behind the digit index.
    always_ff @(posedge clock) begin
        if (new_Game) begin
            seg_an  <= 4'hF;
            seg_cat <= 8'hFF;
        end else begin
            seg_an  <= an_next_s;
            seg_cat <= cat_next_s;
        end
    end

endmodule
